// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Optional HOLD timeout is enabled with ALU_ARB_TIMEOUT_EN.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic             owner;
  logic             win;
  logic             hs;
  logic             drop;
  logic [2:0]       op_q;
  logic [2:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // A lone requester wins; rr_ptr only breaks ties.
  always_comb begin
    win    = req_valid[1] & (~req_valid[0] | rr_ptr);
    win_op = win ? req_op1 : req_op0;
    win_a  = win ? req_a1 : req_a0;
    win_b  = win ? req_b1 : req_b0;
    req_ready = 2'b00;
    if (state == IDLE && rst_n && |req_valid)
      req_ready = win ? 2'b10 : 2'b01;
    hs = (state == HOLD) & rsp_ready[owner];
  end

  assign busy = (state != IDLE);

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err;
  assign drop = (state == HOLD) && !hs &&
                (cnt == CW'(TIMEOUT - 1));
  assign timeout_err = err;
`else
  assign drop = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      op_q       <= 3'b000;
      alu_opcode <= 3'b000;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt        <= '0;
      err        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            owner      <= win;
            op_q       <= (win_op == 3'b111) ? 3'b000 : win_op;
            alu_opcode <= (win_op == 3'b111) ? 3'b000 : win_op;
            alu_a      <= win_a;
            alu_b      <= win_b;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_result;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          alu_opcode <= 3'b000;
          state      <= HOLD;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt        <= '0;
`endif
        end
        HOLD: begin
          if (hs || drop) begin
            rsp_valid <= 2'b00;
            rr_ptr    <= ~owner;
            state     <= IDLE;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          if (drop)
            err <= 1'b1;
          if (!hs && !drop)
            cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
